dout_avg_fifo: RTL and testbench
================================

# dout_avg_fifo

Downstream consumer of the loop-unrolled summation DUT's output stream. Accepts 11-bit sums of eight 8-bit samples over a busy/vld handshake and buffers them in a small FIFO. Converts each sum to an 8-bit average, optionally rounded, and presents it on a busy/vld output port toward the testbench sink or the next stage. Also keeps a running count of delivered averages.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; a power of two, minimum 2.
- CNT_W, 16: width of the delivered-average counter.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- din_busy  output  1  high = FIFO full, no input accepted.
- din_vld  input  1  upstream has a valid sum on din_data.
- din_data  input  11  sum of eight unsigned 8-bit samples, range 0..2040.
- dout_busy  input  1  downstream cannot accept.
- dout_vld  output  1  high = dout_data holds a valid average.
- dout_data  output  8  average of the head FIFO entry.
- avg_cnt  output  CNT_W  number of averages transferred on the dout port.

## Operation
- Transfer rule, both ports: a word moves on a rising edge where vld=1 and busy=0. The producer holds vld and data stable until transfer. Busy may change at any time.
- Storage: DEPTH×11-bit array; write and read pointers of log2(DEPTH) bits that wrap modulo DEPTH; occupancy counter of log2(DEPTH)+1 bits, range 0..DEPTH.
- Push: din_vld && !din_busy. Writes din_data at wr_ptr, advances wr_ptr.
- Pop: dout_vld && !dout_busy. Advances rd_ptr and increments avg_cnt.
- din_busy = (occupancy == DEPTH). There is no full-bypass: a pop in the same cycle does not allow a push while full.
- dout_vld = (occupancy != 0). There is no empty-bypass: data pushed into an empty FIFO is not visible in the same cycle.
- Simultaneous push and pop when 0 < occupancy < DEPTH leaves occupancy unchanged; both pointers advance.
- dout_data = avg(mem[rd_ptr]) when dout_vld=1, else 8'd0. The result is combinational from registered state only, with no path from din_* or dout_busy.
- Arithmetic, rounded: (sum + 4) >> 3, computed in 12 bits. The maximum is (2040+4)>>3 = 255, so no saturation is needed.
- Arithmetic, truncated: sum >> 3.
- avg_cnt wraps from 2^CNT_W−1 to 0.
- The block does not check din_data > 2040. Out-of-range values give the rounded or truncated result masked to 8 bits.

## Timing
- Reset, async assert: occupancy=0, pointers=0, avg_cnt=0. Outputs go immediately to din_busy=0, dout_vld=0, dout_data=0. Array contents are don't-care.
- Reset mid-operation discards all buffered words. No transfer is reported during reset, and din_busy=0 throughout.
- Reset release: the first push can occur on the first rising edge with rst low.
- Latency: a word pushed at edge N gives dout_vld=1 in the cycle after edge N. It can pop at edge N+1 at the earliest.
- Throughput: one word per cycle sustained when dout_busy=0 and occupancy is neither 0 nor DEPTH.
- Full: din_busy rises in the cycle after the push that makes occupancy DEPTH. It falls in the cycle after the next pop.
- Empty: dout_vld falls in the cycle after the pop that makes occupancy 0.

## Configuration
- AVG_ROUND_EN defined: rounding arithmetic, (sum+4)>>3, round-half-up.
- AVG_ROUND_EN undefined: truncating arithmetic, sum>>3.
- All other behaviour and timing are identical in both builds.

## Test plan
- Single word, dout_busy=0: push 2040 → dout_vld=1 next cycle, dout_data=255, popped on the following edge, avg_cnt=1.
- Rounding: push 11, 12, 0, 1027 → with AVG_ROUND_EN: 1, 2, 0, 128; without: 1, 1, 0, 128.
- Fill/backpressure, DEPTH=4, dout_busy=1: push 8, 16, 24, 32 → din_busy=1 after the 4th push and a 5th din_vld word is held. Release dout_busy → outputs in order 1, 2, 3, 4, then the held word.
- Full plus simultaneous pop: at occupancy 4, dout_busy=0 and din_vld=1 → that edge pops only. Next cycle din_busy=0 and the push is accepted; no word is lost or duplicated.
- Pointer wrap: stream 20 words 8·k for k=0..19 with dout_busy toggling every cycle → outputs 0..19 in order, avg_cnt=20.
- Async reset mid-stream: with occupancy 3, pulse rst between edges → din_busy=0, dout_vld=0, dout_data=0 immediately, avg_cnt=0. A subsequent push of 80 yields 10.

Source files
------------

// File: rtl/dout_avg_fifo.sv
// dout_avg_fifo: buffers 11-bit sums of eight 8-bit samples in a small FIFO
// and presents the per-entry 8-bit average on a busy/vld output port, while
// counting the averages delivered downstream.
// Build option: define AVG_ROUND_EN for round-half-up averaging
// ((sum + 4) >> 3); leave it undefined for truncating averaging (sum >> 3).

module dout_avg_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             din_busy,
    input  logic             din_vld,
    input  logic [10:0]      din_data,
    input  logic             dout_busy,
    output logic             dout_vld,
    output logic [7:0]       dout_data,
    output logic [CNT_W-1:0] avg_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_OCC = (AW + 1)'(DEPTH);
    localparam logic [AW:0]    OCC_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Average of one buffered sum; out-of-range sums are simply masked to 8 bits.
    function automatic logic [7:0] avg8(input logic [10:0] sum);
`ifdef AVG_ROUND_EN
        return 8'(({1'b0, sum} + 12'd4) >> 3'd3);
`else
        return 8'({1'b0, sum} >> 3'd3);
`endif
    endfunction

    logic [10:0]      mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      occ_r;
    logic [CNT_W-1:0] cnt_r;
    logic             push_s;
    logic             pop_s;

    // Port flags decode straight from the registered occupancy; no bypass paths.
    assign din_busy = (occ_r == FULL_OCC);
    assign dout_vld = (occ_r != {(AW + 1){1'b0}});
    assign push_s   = din_vld && !din_busy;
    assign pop_s    = dout_vld && !dout_busy;
    assign avg_cnt  = cnt_r;

    // Head-of-FIFO average, forced to zero while the FIFO is empty.
    always_comb begin
        dout_data = 8'd0;
        if (dout_vld) begin
            dout_data = avg8(mem_r[rd_ptr_r]);
        end else begin
            dout_data = 8'd0;
        end
    end

    // Storage array; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= din_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Occupancy tracks push/pop; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_r <= {(AW + 1){1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + OCC_ONE;
                2'b01:   occ_r <= occ_r - OCC_ONE;
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Delivered-average counter, wrapping at its width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (pop_s) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: tb/tb_dout_avg_fifo.sv
// Directed self-checking bench for dout_avg_fifo (DEPTH=4, CNT_W=16).
// Inputs change and outputs are sampled 1 ns after each rising edge.

module tb_dout_avg_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        din_busy;
    logic        din_vld;
    logic [10:0] din_data;
    logic        dout_busy;
    logic        dout_vld;
    logic [7:0]  dout_data;
    logic [15:0] avg_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    dout_avg_fifo #(.DEPTH(4), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .din_busy  (din_busy),
        .din_vld   (din_vld),
        .din_data  (din_data),
        .dout_busy (dout_busy),
        .dout_vld  (dout_vld),
        .dout_data (dout_data),
        .avg_cnt   (avg_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; din_vld = 1'b1; din_data = 11'd100; dout_busy = 1'b0;
        #1;
        n_checks++;
        if ({din_busy, dout_vld, dout_data, avg_cnt} !== 26'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got busy=%b vld=%b data=%0d cnt=%0d, want all 0",
                     din_busy, dout_vld, dout_data, avg_cnt);
        end
        step();
        n_checks++;
        if (dout_vld !== 1'b0 || din_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_no_push: got vld=%b busy=%b, want 0 0", dout_vld, din_busy);
        end
        rst = 1'b0; din_vld = 1'b0;
    endtask

    task automatic test_single();
        din_vld = 1'b1; din_data = 11'd2040; dout_busy = 1'b0;
        step();
        din_vld = 1'b0;
        n_checks++;
        if (dout_vld !== 1'b1 || dout_data !== 8'd255) begin
            n_errors++;
            $display("FAIL single_visible: got vld=%b data=%0d, want 1 255", dout_vld, dout_data);
        end
        step();
        exp_cnt++;
        n_checks++;
        if (dout_vld !== 1'b0 || dout_data !== 8'd0 || avg_cnt !== 16'(exp_cnt)) begin
            n_errors++;
            $display("FAIL single_popped: got vld=%b data=%0d cnt=%0d, want 0 0 %0d",
                     dout_vld, dout_data, avg_cnt, exp_cnt);
        end
    endtask

    task automatic test_rounding();
        logic [10:0] sums [5];
        logic [7:0]  want [5];
        sums = '{11'd11, 11'd12, 11'd0, 11'd1027, 11'd2047};
`ifdef AVG_ROUND_EN
        want = '{8'd1, 8'd2, 8'd0, 8'd128, 8'd0};
`else
        want = '{8'd1, 8'd1, 8'd0, 8'd128, 8'd255};
`endif
        dout_busy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din_vld = 1'b1; din_data = sums[i];
            step();
            din_vld = 1'b0;
            n_checks++;
            if (dout_vld !== 1'b1 || dout_data !== want[i]) begin
                n_errors++;
                $display("FAIL rounding_%0d: sum=%0d got vld=%b data=%0d, want 1 %0d",
                         i, sums[i], dout_vld, dout_data, want[i]);
            end
            step();
            exp_cnt++;
        end
        n_checks++;
        if (avg_cnt !== 16'(exp_cnt)) begin
            n_errors++;
            $display("FAIL rounding_cnt: got %0d, want %0d", avg_cnt, exp_cnt);
        end
    endtask

    task automatic test_fill_backpressure();
        logic [7:0] want [4];
        want = '{8'd2, 8'd3, 8'd4, 8'd5};
        dout_busy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if (din_busy !== 1'b0) begin
                n_errors++;
                $display("FAIL fill_not_busy_%0d: got busy=%b, want 0", i, din_busy);
            end
            din_vld = 1'b1; din_data = 11'(8 * i);
            step();
        end
        din_data = 11'd40;
        step();
        step();
        n_checks++;
        if (din_busy !== 1'b1 || dout_vld !== 1'b1 || dout_data !== 8'd1) begin
            n_errors++;
            $display("FAIL fill_full: got busy=%b vld=%b data=%0d, want 1 1 1",
                     din_busy, dout_vld, dout_data);
        end
        // Release backpressure while the fifth word is still offered.
        dout_busy = 1'b0;
        step();
        exp_cnt++;
        n_checks++;
        if (din_busy !== 1'b0 || dout_data !== want[0]) begin
            n_errors++;
            $display("FAIL full_pop_only: got busy=%b data=%0d, want 0 %0d",
                     din_busy, dout_data, want[0]);
        end
        step();
        exp_cnt++;
        din_vld = 1'b0;
        for (int i = 1; i < 4; i++) begin
            n_checks++;
            if (dout_vld !== 1'b1 || dout_data !== want[i]) begin
                n_errors++;
                $display("FAIL drain_%0d: got vld=%b data=%0d, want 1 %0d",
                         i, dout_vld, dout_data, want[i]);
            end
            step();
            exp_cnt++;
        end
        n_checks++;
        if (dout_vld !== 1'b0 || avg_cnt !== 16'(exp_cnt)) begin
            n_errors++;
            $display("FAIL drain_empty: got vld=%b cnt=%0d, want 0 %0d",
                     dout_vld, avg_cnt, exp_cnt);
        end
    endtask

    task automatic test_wrap();
        int  k = 0;
        int  idx = 0;
        int  cycles = 0;
        bit  push_w;
        bit  pop_w;
        dout_busy = 1'b1;
        while (idx < 20 && cycles < 200) begin
            dout_busy = ~dout_busy;
            din_vld   = (k < 20);
            din_data  = 11'(8 * k);
            #1;
            push_w = din_vld && !din_busy;
            pop_w  = dout_vld && !dout_busy;
            if (pop_w) begin
                n_checks++;
                if (dout_data !== 8'(idx)) begin
                    n_errors++;
                    $display("FAIL wrap_out_%0d: got %0d, want %0d", idx, dout_data, idx);
                end
            end
            step();
            if (push_w) k++;
            if (pop_w) begin
                idx++;
                exp_cnt++;
            end
            cycles++;
        end
        din_vld = 1'b0; dout_busy = 1'b0;
        n_checks++;
        if (idx != 20) begin
            n_errors++;
            $display("FAIL wrap_timeout: got %0d outputs, want 20", idx);
        end
        n_checks++;
        if (avg_cnt !== 16'(exp_cnt) || dout_vld !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_cnt: got cnt=%0d vld=%b, want %0d 0", avg_cnt, dout_vld, exp_cnt);
        end
    endtask

    task automatic test_async_reset();
        dout_busy = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            din_vld = 1'b1; din_data = 11'(8 * i);
            step();
        end
        din_vld = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        exp_cnt = 0;
        n_checks++;
        if ({din_busy, dout_vld, dout_data, avg_cnt} !== 26'd0) begin
            n_errors++;
            $display("FAIL async_reset: got busy=%b vld=%b data=%0d cnt=%0d, want all 0",
                     din_busy, dout_vld, dout_data, avg_cnt);
        end
        #1;
        rst = 1'b0;
        dout_busy = 1'b0;
        step();
        din_vld = 1'b1; din_data = 11'd80;
        step();
        din_vld = 1'b0;
        n_checks++;
        if (dout_vld !== 1'b1 || dout_data !== 8'd10) begin
            n_errors++;
            $display("FAIL post_reset_push: got vld=%b data=%0d, want 1 10", dout_vld, dout_data);
        end
        step();
        n_checks++;
        if (avg_cnt !== 16'd1 || dout_vld !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset_pop: got cnt=%0d vld=%b, want 1 0", avg_cnt, dout_vld);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rounding();
        test_fill_backpressure();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
